// File: rtl/regfile_port_arbiter_if.sv
// regfile_port_arbiter_if: request/response handshakes for the two requesters.
interface regfile_port_arbiter_if #(parameter int DATA_W = 32, parameter int ADDR_W = 2);
   logic              req0_valid, req0_we, req0_ready;
   logic [ADDR_W-1:0] req0_addr;
   logic [DATA_W-1:0] req0_wdata;
   logic              req1_valid, req1_we, req1_ready;
   logic [ADDR_W-1:0] req1_addr;
   logic [DATA_W-1:0] req1_wdata;
   logic              rsp0_valid, rsp0_ready;
   logic [DATA_W-1:0] rsp0_rdata;
   logic              rsp1_valid, rsp1_ready;
   logic [DATA_W-1:0] rsp1_rdata;
   modport master (
      output req0_valid, req0_we, req0_addr, req0_wdata, rsp0_ready,
      output req1_valid, req1_we, req1_addr, req1_wdata, rsp1_ready,
      input  req0_ready, rsp0_valid, rsp0_rdata, req1_ready, rsp1_valid, rsp1_rdata
   );
   modport slave (
      input  req0_valid, req0_we, req0_addr, req0_wdata, rsp0_ready,
      input  req1_valid, req1_we, req1_addr, req1_wdata, rsp1_ready,
      output req0_ready, rsp0_valid, rsp0_rdata, req1_ready, rsp1_valid, rsp1_rdata
   );
endinterface

// File: rtl/regfile_port_arbiter.sv
// regfile_port_arbiter: shares a two-read-port register file between two requesters,
// round-robin on the single write port, registered back-pressurable read responses.
module regfile_port_arbiter #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   regfile_port_arbiter_if.slave bus,
   output logic [ADDR_W-1:0]     rf_rs1,
   output logic [ADDR_W-1:0]     rf_rs2,
   input  logic [DATA_W-1:0]     rf_read1,
   input  logic [DATA_W-1:0]     rf_read2,
   output logic                  rf_wr,
   output logic [ADDR_W-1:0]     rf_waddr,
   output logic [DATA_W-1:0]     rf_wdata
);
   logic [1:0]        valid, we, open, grant, ready, fire, wr, rd, rsp_ready;
   logic [1:0]        rsp_valid_q, rsp_valid_d;
   logic [ADDR_W-1:0] addr [2];
   logic [DATA_W-1:0] wdata [2];
   logic [DATA_W-1:0] rf_rd [2];
   logic [DATA_W-1:0] rdata_q [2];
   logic [DATA_W-1:0] rdata_d [2];
   logic              prio_q, prio_d, both_w;
   assign valid     = {bus.req1_valid, bus.req0_valid};
   assign we        = {bus.req1_we, bus.req0_we};
   assign rsp_ready = {bus.rsp1_ready, bus.rsp0_ready};
   assign addr[0]   = bus.req0_addr;
   assign addr[1]   = bus.req1_addr;
   assign wdata[0]  = bus.req0_wdata;
   assign wdata[1]  = bus.req1_wdata;
   assign rf_rd[0]  = rf_read1;
   assign rf_rd[1]  = rf_read2;
   assign rf_rs1    = bus.req0_addr;
   assign rf_rs2    = bus.req1_addr;
   assign bus.req0_ready = ready[0];
   assign bus.req1_ready = ready[1];
   assign bus.rsp0_valid = rsp_valid_q[0];
   assign bus.rsp1_valid = rsp_valid_q[1];
   assign bus.rsp0_rdata = rdata_q[0];
   assign bus.rsp1_rdata = rdata_q[1];
   // Writes are refused while reset is held so no write strobe can leak out.
   always_comb begin
      both_w   = &(valid & we);
      grant    = both_w ? (prio_q ? 2'b10 : 2'b01) : 2'b11;
      open     = ~rsp_valid_q | rsp_ready;
      ready    = open & (~we | (grant & {2{rst_n}}));
      fire     = valid & ready;
      wr       = fire & we;
      rd       = fire & ~we;
      rf_wr    = |wr;
      rf_waddr = wr[0] ? addr[0] : wr[1] ? addr[1] : '0;
      rf_wdata = wr[0] ? wdata[0] : wr[1] ? wdata[1] : '0;
      prio_d   = (both_w && |wr) ? ~prio_q : prio_q;
      for (int n = 0; n < 2; n++) begin
         rsp_valid_d[n] = rd[n] | (rsp_valid_q[n] & ~rsp_ready[n]);
         rdata_d[n]     = rd[n] ? rf_rd[n] : rdata_q[n];
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid_q <= '0;
         rdata_q     <= '{default: '0};
         prio_q      <= 1'b0;
      end else begin
         rsp_valid_q <= rsp_valid_d;
         rdata_q     <= rdata_d;
         prio_q      <= prio_d;
      end
   end
endmodule
